// File: rtl/clock_seq_gate.sv
// clock_seq_gate: power-up clock sequencer for NCH glitch-free gated clocks.
// After reset it waits UP_DELAY ticks, then turns channels on one by one,
// STAGGER ticks apart, and turns them off in reverse order when run drops.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_WAIT | initial power-up delay after reset, channels all off
// ST_UP   | stepping channels on, lowest cleared bit first
// ST_ON   | all channels on, sequence complete
// ST_DOWN | stepping channels off, highest set bit first
// ST_OFF  | all channels off, idle until run rises
module clock_seq_gate #(
    parameter int NCH      = 4,
    parameter int PRE_DIV  = 50,
    parameter int PRE_W    = 13,
    parameter int UP_DELAY = 10,
    parameter int STAGGER  = 2,
    parameter int DLY_W    = 14
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           run,
    input  logic [NCH-1:0] force_off,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] ch_on,
    output logic           seq_busy,
    output logic           seq_done
);

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_UP   = 3'd1,
        ST_ON   = 3'd2,
        ST_DOWN = 3'd3,
        ST_OFF  = 3'd4
    } state_t;

    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(PRE_DIV);
    localparam logic [DLY_W-1:0] WAIT_TC  = DLY_W'(UP_DELAY);
    localparam logic [DLY_W-1:0] STEP_TC  = DLY_W'(STAGGER - 1);
    localparam logic [NCH-1:0]   CH_FIRST = NCH'(1);

    state_t           state_q, state_d;
    logic [NCH-1:0]   ch_on_q, ch_on_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             step_now_q, step_now_d;

    logic             tick;
    logic             restart;
    logic [NCH-1:0]   ch_up;
    logic [NCH-1:0]   ch_dn;
    logic [NCH-1:0]   en_d;
    logic [NCH-1:0]   lat_en;

    assign tick  = (pre_q == PRE_TC);
    assign ch_up = (ch_on_q << 1) | CH_FIRST;
    assign ch_dn = ch_on_q >> 1;
    assign ch_on = ch_on_q;

    // State, channel enables, prescaler and tick counter registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            ch_on_q    <= '0;
            pre_q      <= '0;
            cnt_q      <= '0;
            step_now_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_on_q    <= ch_on_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            step_now_q <= step_now_d;
        end
    end

    // Next state, channel stepping and timer restart.
    // A direction change arms step_now so the first step lands on the very
    // next edge; later steps wait a full STAGGER interval. WAIT acts one edge
    // after its last tick because the release edge itself starts the count,
    // which makes the power-up delay exactly UP_DELAY*(PRE_DIV+1) cycles.
    always_comb begin
        state_d    = state_q;
        ch_on_d    = ch_on_q;
        step_now_d = 1'b0;
        restart    = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == WAIT_TC) begin
                    restart = 1'b1;
                    if (run) begin
                        ch_on_d = CH_FIRST;
                        state_d = (NCH == 1) ? ST_ON : ST_UP;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
            end
            ST_UP: begin
                if (!run) begin
                    restart = 1'b1;
                    if (ch_on_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d    = ST_DOWN;
                        step_now_d = 1'b1;
                    end
                end else if (step_now_q || (tick && (cnt_q == STEP_TC))) begin
                    restart = 1'b1;
                    ch_on_d = ch_up;
                    if (ch_up[NCH-1]) begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                restart = 1'b1;
                if (!run) begin
                    state_d    = ST_DOWN;
                    step_now_d = 1'b1;
                end
            end
            ST_DOWN: begin
                if (run) begin
                    restart = 1'b1;
                    if (&ch_on_q) begin
                        state_d = ST_ON;
                    end else begin
                        state_d    = ST_UP;
                        step_now_d = 1'b1;
                    end
                end else if (step_now_q || (tick && (cnt_q == STEP_TC))) begin
                    restart = 1'b1;
                    ch_on_d = ch_dn;
                    if (ch_dn == '0) begin
                        state_d = ST_OFF;
                    end
                end
            end
            ST_OFF: begin
                restart = 1'b1;
                if (run) begin
                    state_d    = ST_UP;
                    step_now_d = 1'b1;
                end
            end
            default: begin
                restart = 1'b1;
                ch_on_d = '0;
                state_d = ST_WAIT;
            end
        endcase

        if (restart) begin
            pre_d = '0;
            cnt_d = '0;
        end else begin
            pre_d = tick ? '0 : (pre_q + PRE_W'(1));
            cnt_d = tick ? (cnt_q + DLY_W'(1)) : cnt_q;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        seq_busy = 1'b0;
        seq_done = 1'b0;
        unique case (state_q)
            ST_WAIT, ST_UP, ST_DOWN: seq_busy = 1'b1;
            ST_ON:                   seq_done = &ch_on_q;
            default:                 ;
        endcase
    end

    // Gate request: sequencer enable unless the channel is forced off.
    always_comb begin
        en_d = ch_on_q & ~force_off;
    end

    // Enable latch, open only while clk_in is low so a gate change can never
    // clip a high phase already in progress.
    always_latch begin
        if (!clk_in) begin
            lat_en = en_d;
        end
    end

    assign clk_out = {NCH{clk_in}} & lat_en;

endmodule
